alphamission_palette_load_ctrl: RTL and testbench

//  Sequences the ROM download of the three 1Kx4 colour PROMs (R/G/B-slice, F12/F13/F14) in the

---
 rtl/alphamission_palette_load_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alphamission_palette_load_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alphamission_palette_load_ctrl.sv
// Palette PROM download sequencer for the three 1Kx4 colour PROMs (F12/F13/F14).
// Latency: 1 clk from ioctl write to prom_we; pal_ready 2 clks after download falls.
// Backpressure: none; ioctl writes are taken unconditionally. Writes outside LOAD or outside the window are dropped.
//
// Optional feature macro: ALPHAMISSION_PAL_CHECKSUM_EN
//   When defined, adds pal_sum (running 16-bit nibble sum of the session).
//   It also adds pal_sum_exp; CHECK then also requires pal_sum == pal_sum_exp.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   CK1                 pixel clock enable (one clk wide)
//   ioctl_download      download session active
//   ioctl_addr/data/wr  hps_io download byte stream
//   DISP                raw display enable from video timing
//   prom_we/addr/din    registered PROM write port (prom_we one-hot per PROM)
//   pal_ready, pal_err  palette loaded / last session failed
//   disp_gated          DISP & pal_ready, updated only on CK1
module alphamission_palette_load_ctrl #(
  parameter logic [24:0] BASE_ADDR  = 25'h80000,
  parameter int          PROM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CK1,
  input  logic        ioctl_download,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        DISP,
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
  input  logic [15:0] pal_sum_exp,
  output logic [15:0] pal_sum,
`endif
  output logic [2:0]  prom_we,
  output logic [9:0]  prom_addr,
  output logic [3:0]  prom_din,
  output logic        pal_ready,
  output logic        pal_err,
  output logic        disp_gated
);

  localparam logic [11:0] D1       = 12'(PROM_DEPTH);
  localparam logic [11:0] D2       = 12'(2 * PROM_DEPTH);
  localparam logic [11:0] WIN_SIZE = 12'(3 * PROM_DEPTH);
  localparam logic [24:0] WIN_END  = BASE_ADDR + 25'(3 * PROM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_READY,
    S_ERROR
  } state_t;

  state_t      state;
  logic [11:0] exp_ptr;
  logic        seq_err;

  logic        in_win;
  logic [24:0] off_full;
  logic [11:0] off;
  logic [11:0] loc;
  logic [2:0]  sel;
  logic        wr_acc;
  logic        sum_ok;

  // Window decode and PROM select. The window is at most 3K bytes, so the low 12 bits of the offset suffice.
  always_comb begin
    in_win   = (ioctl_addr >= BASE_ADDR) && (ioctl_addr < WIN_END);
    off_full = ioctl_addr - BASE_ADDR;
    off      = off_full[11:0];
    sel      = 3'b000;
    loc      = 12'd0;
    if (off < D1) begin
      sel = 3'b001;
      loc = off;
    end else if (off < D2) begin
      sel = 3'b010;
      loc = off - D1;
    end else begin
      sel = 3'b100;
      loc = off - D2;
    end
    wr_acc = (state == S_LOAD) && ioctl_wr && in_win;
  end

`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
  assign sum_ok = (pal_sum == pal_sum_exp);
`else
  assign sum_ok = 1'b1;
`endif

  // Bits that the decode never needs. ioctl_data upper nibble is unused, and so are the offset above 12 bits.
  // The top of the in-PROM address is also unused.
  logic unused_bits;
  assign unused_bits = ^{ioctl_data[7:4], off_full[24:12], loc[11:10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      exp_ptr    <= 12'd0;
      seq_err    <= 1'b0;
      prom_we    <= 3'b000;
      prom_addr  <= 10'd0;
      prom_din   <= 4'h0;
      pal_ready  <= 1'b0;
      pal_err    <= 1'b0;
      disp_gated <= 1'b0;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
      pal_sum    <= 16'd0;
`endif
    end else begin
      // Strobe is a single-clk pulse; address and data hold their last value.
      prom_we <= 3'b000;

      // wr_acc is only ever true in LOAD, so the session-clearing assignments below never collide with these.
      if (wr_acc) begin
        prom_we   <= sel;
        prom_addr <= loc[9:0];
        prom_din  <= ioctl_data[3:0];
        if (off != exp_ptr)
          seq_err <= 1'b1;
        else if (exp_ptr != WIN_SIZE)
          exp_ptr <= exp_ptr + 12'd1;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
        pal_sum <= pal_sum + {12'd0, ioctl_data[3:0]};
`endif
      end

      // Sample only on the pixel enable so the gated enable cannot change mid-pixel.
      if (CK1)
        disp_gated <= DISP & pal_ready;

      case (state)
        S_IDLE: begin
          if (ioctl_download) begin
            state   <= S_LOAD;
            exp_ptr <= 12'd0;
            seq_err <= 1'b0;
            pal_err <= 1'b0;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
            pal_sum <= 16'd0;
`endif
          end
        end
        S_LOAD: begin
          // A write in the same cycle as download falling has already been counted above when CHECK runs.
          if (!ioctl_download)
            state <= S_CHECK;
        end
        S_CHECK: begin
          if ((exp_ptr == WIN_SIZE) && !seq_err && sum_ok) begin
            state     <= S_READY;
            pal_ready <= 1'b1;
          end else begin
            state     <= S_ERROR;
            pal_err   <= 1'b1;
            pal_ready <= 1'b0;
          end
        end
        S_READY, S_ERROR: begin
          if (ioctl_download) begin
            state     <= S_LOAD;
            pal_ready <= 1'b0;
            pal_err   <= 1'b0;
            exp_ptr   <= 12'd0;
            seq_err   <= 1'b0;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
            pal_sum   <= 16'd0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alphamission_palette_load_ctrl.sv
// Bench for alphamission_palette_load_ctrl.
// Directed vector table for the single-cycle behaviour.
// Hand-written loops cover full, short, gapped and reset-interrupted downloads.
module tb_alphamission_palette_load_ctrl;

  logic        clk = 1'b0;
  logic        rst, CK1, ioctl_download, ioctl_wr, DISP;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [2:0]  prom_we;
  logic [9:0]  prom_addr;
  logic [3:0]  prom_din;
  logic        pal_ready, pal_err, disp_gated;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
  logic [15:0] pal_sum_exp, pal_sum;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alphamission_palette_load_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .CK1            (CK1),
    .ioctl_download (ioctl_download),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .DISP           (DISP),
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
    .pal_sum_exp    (pal_sum_exp),
    .pal_sum        (pal_sum),
`endif
    .prom_we        (prom_we),
    .prom_addr      (prom_addr),
    .prom_din       (prom_din),
    .pal_ready      (pal_ready),
    .pal_err        (pal_err),
    .disp_gated     (disp_gated)
  );

  typedef struct {
    logic        rst, dl, wr;
    logic [24:0] a;
    logic [7:0]  d;
    logic        ck, ds;
    logic [2:0]  we;
    logic [9:0]  pa;
    logic [3:0]  din;
    logic        rdy, err, dg;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, and settle 1 time unit after it.
  task automatic step(input logic r, input logic dl, input logic wr, input logic [24:0] a,
                      input logic [7:0] d, input logic ck, input logic ds);
    rst = r; ioctl_download = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_data = d;
    CK1 = ck; DISP = ds;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; CK1 = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; DISP = 1'b0;
    ioctl_addr = 25'd0; ioctl_data = 8'd0;
`ifdef ALPHAMISSION_PAL_CHECKSUM_EN
    // 192 runs of 0..15 per full image.
    pal_sum_exp = 16'd23040;
`endif

    //             rst   dl    wr    addr          data   ck    ds  | we      pa      din   rdy   err   dg
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 25'h80000, 8'h05, 1'b1, 1'b1, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 25'h80001, 8'h06, 1'b0, 1'b1, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 25'h80000, 8'h03, 1'b0, 1'b0, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 25'h80000, 8'h00, 1'b0, 1'b0, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 25'h7FFFF, 8'h07, 1'b0, 1'b0, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 25'h80C00, 8'h07, 1'b0, 1'b0, 3'b000, 10'd0,   4'h0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 25'h80000, 8'h0A, 1'b0, 1'b0, 3'b001, 10'd0,   4'hA, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 25'h80001, 8'h1B, 1'b0, 1'b0, 3'b001, 10'd1,   4'hB, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 25'h80002, 8'h0C, 1'b0, 1'b0, 3'b000, 10'd1,   4'hB, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 25'h80BFF, 8'h03, 1'b0, 1'b0, 3'b100, 10'h3FF, 4'h3, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 25'h80400, 8'h06, 1'b0, 1'b0, 3'b010, 10'd0,   4'h6, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 25'h80000, 8'h00, 1'b0, 1'b0, 3'b000, 10'd0,   4'h6, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 25'h80000, 8'h00, 1'b0, 1'b0, 3'b000, 10'd0,   4'h6, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 25'h80000, 8'h00, 1'b1, 1'b1, 3'b000, 10'd0,   4'h6, 1'b0, 1'b1, 1'b0};

    for (int v = 0; v < 14; v++) begin
      step(tbl[v].rst, tbl[v].dl, tbl[v].wr, tbl[v].a, tbl[v].d, tbl[v].ck, tbl[v].ds);
      chk($sformatf("tbl%0d prom_we", v),    32'(prom_we),    32'(tbl[v].we));
      chk($sformatf("tbl%0d prom_addr", v),  32'(prom_addr),  32'(tbl[v].pa));
      chk($sformatf("tbl%0d prom_din", v),   32'(prom_din),   32'(tbl[v].din));
      chk($sformatf("tbl%0d pal_ready", v),  32'(pal_ready),  32'(tbl[v].rdy));
      chk($sformatf("tbl%0d pal_err", v),    32'(pal_err),    32'(tbl[v].err));
      chk($sformatf("tbl%0d disp_gated", v), 32'(disp_gated), 32'(tbl[v].dg));
    end

    // Full in-order load. The last byte coincides with download falling.
    step(1'b1, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    chk("reset pal_err", 32'(pal_err), 32'd0);
    step(1'b0, 1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3072; i++) begin
      step(1'b0, (i != 3071), 1'b1, 25'h80000 + 25'(i), 8'(i), 1'b0, 1'b0);
      chk($sformatf("full we %0d", i),   32'(prom_we),   32'(1 << (i / 1024)));
      chk($sformatf("full addr %0d", i), 32'(prom_addr), 32'(i % 1024));
      chk($sformatf("full din %0d", i),  32'(prom_din),  32'(i & 15));
    end
    chk("full ready in CHECK", 32'(pal_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    chk("full pal_ready", 32'(pal_ready), 32'd1);
    chk("full pal_err",   32'(pal_err),   32'd0);
    chk("full we idle",   32'(prom_we),   32'd0);

    // A write while READY is ignored.
    step(1'b0, 1'b0, 1'b1, 25'h80000, 8'h05, 1'b0, 1'b0);
    chk("ready wr we",    32'(prom_we),   32'd0);
    chk("ready wr ready", 32'(pal_ready), 32'd1);

    // DISP gating: the output follows DISP & pal_ready only on CK1.
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
    chk("dg no ck1 hold0", 32'(disp_gated), 32'd0);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b1, 1'b1);
    chk("dg ck1 rise",     32'(disp_gated), 32'd1);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    chk("dg no ck1 hold1", 32'(disp_gated), 32'd1);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b1, 1'b0);
    chk("dg ck1 fall",     32'(disp_gated), 32'd0);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b1, 1'b1);
    chk("dg ck1 rise2",    32'(disp_gated), 32'd1);
    step(1'b0, 1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
    chk("reload ready drop", 32'(pal_ready),  32'd0);
    chk("reload dg hold",    32'(disp_gated), 32'd1);
    step(1'b0, 1'b1, 1'b0, 25'h0, 8'h0, 1'b1, 1'b1);
    chk("reload dg ck1",     32'(disp_gated), 32'd0);

    // Short image: the session stops after 0x80BFE.
    for (int i = 0; i < 3071; i++) begin
      step(1'b0, 1'b1, 1'b1, 25'h80000 + 25'(i), 8'(i), 1'b0, 1'b1);
    end
    chk("short last we",   32'(prom_we),   32'b100);
    chk("short last addr", 32'(prom_addr), 32'h3FE);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b1, 1'b1);
    chk("short pal_err",   32'(pal_err),    32'd1);
    chk("short pal_ready", 32'(pal_ready),  32'd0);
    chk("short dg",        32'(disp_gated), 32'd0);

    // Gap: 0x80400 is skipped. The writes are still forwarded, but the session ends in ERROR.
    step(1'b0, 1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    chk("gap err cleared", 32'(pal_err), 32'd0);
    for (int i = 0; i < 3072; i++) begin
      if (i != 1024) begin
        step(1'b0, 1'b1, 1'b1, 25'h80000 + 25'(i), 8'(i), 1'b0, 1'b0);
        if (i == 1025) begin
          chk("gap fwd we",   32'(prom_we),   32'b010);
          chk("gap fwd addr", 32'(prom_addr), 32'd1);
          chk("gap fwd din",  32'(prom_din),  32'd1);
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    chk("gap pal_err",   32'(pal_err),   32'd1);
    chk("gap pal_ready", 32'(pal_ready), 32'd0);

    // Reset mid-session drops the pending strobe and returns the FSM to IDLE.
    step(1'b0, 1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 25'h80000, 8'h09, 1'b0, 1'b0);
    chk("rst mid we",  32'(prom_we), 32'd0);
    chk("rst mid err", 32'(pal_err), 32'd0);
    step(1'b0, 1'b1, 1'b1, 25'h80000, 8'h09, 1'b0, 1'b0);
    chk("post rst idle we", 32'(prom_we), 32'd0);
    step(1'b0, 1'b1, 1'b1, 25'h80000, 8'h09, 1'b0, 1'b0);
    chk("post rst load we",  32'(prom_we),  32'b001);
    chk("post rst load din", 32'(prom_din), 32'h9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
